// File: rtl/riptide_int_pkg.sv
// Shared types and defaults for the riptide interrupt entry/return sequencer.
package riptide_int_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic        ie;
        logic [2:0]  level;
    } stack_entry_t;

    localparam logic [15:0] DEFAULT_VECTOR_BASE  = 16'h0010;
    localparam int          DEFAULT_VECTOR_SHIFT = 2;

    // Vector address wraps modulo 2^16.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input int          shift,
                                                input logic [2:0]  idx);
        logic [15:0] offset;
        offset = {13'b0, idx} << shift;
        return base + offset;
    endfunction

endpackage

// File: rtl/int_return_stack.sv
// LIFO of saved interrupt context; push and pop are never issued together.
module int_return_stack
    import riptide_int_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  stack_entry_t push_data,
    input  logic         pop,
    output stack_entry_t top,
    output logic [AW:0]  depth,
    output logic         full
);

    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    stack_entry_t  mem_q [DEPTH];
    logic [AW:0]   depth_q;
    logic [AW:0]   top_cnt;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    assign top_cnt = depth_q - 1'b1;
    assign top_idx = top_cnt[AW-1:0];
    assign wr_idx  = depth_q[AW-1:0];
    assign full    = (depth_q == DEPTH_CNT);
    assign depth   = depth_q;
    assign top     = (depth_q != '0) ? mem_q[top_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[wr_idx] <= push_data;
            depth_q       <= depth_q + 1'b1;
        end else if (pop && (depth_q != '0)) begin
            depth_q <= depth_q - 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / return-from-interrupt sequencer with nested context stack
// and a fixed-length fetch flush after every redirect.
module interrupt_sequencer
    import riptide_int_pkg::*;
#(
    parameter logic [15:0] VECTOR_BASE  = DEFAULT_VECTOR_BASE,
    parameter int          VECTOR_SHIFT = DEFAULT_VECTOR_SHIFT,
    parameter int          DEPTH        = 4,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       int_rq,
    input  logic [2:0]                 int_addr,
    input  logic                       inst_boundary,
    input  logic [15:0]                pc_in,
    input  logic                       reti,
    input  logic                       set_ie,
    input  logic                       clr_ie,
    output logic                       take_int,
    output logic [15:0]                vector_pc,
    output logic                       restore,
    output logic [15:0]                restore_pc,
    output logic                       stall,
    output logic                       ie,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       in_service,
    output logic [2:0]                 cur_level,
    output logic                       err_underflow,
    output seq_state_e                 dbg_state
);

    localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

    seq_state_e   state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         ie_q, ie_d;
    logic         take_q, take_d;
    logic         rest_q, rest_d;
    logic [15:0]  vpc_q, vpc_d;
    logic [15:0]  rpc_q, rpc_d;
    logic         err_q, err_d;

    logic                   stk_push, stk_pop, stk_full;
    stack_entry_t           stk_top, stk_in;
    logic [$clog2(DEPTH):0] stk_depth;
    logic                   accept, do_ret, underflow;

    assign stk_in = '{pc: pc_in, ie: ie_q, level: int_addr};

    int_return_stack #(.DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .push_data (stk_in),
        .pop       (stk_pop),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full)
    );

    // reti outranks a simultaneous request; the request is seen again after the flush.
    assign accept    = (state_q == RUN) && int_rq && ie_q && inst_boundary && !reti && !stk_full;
    assign do_ret    = (state_q == RUN) && reti && (stk_depth != '0);
    assign underflow = (state_q == RUN) && reti && (stk_depth == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ie_d     = ie_q;
        take_d   = 1'b0;
        rest_d   = 1'b0;
        vpc_d    = vpc_q;
        rpc_d    = rpc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        if (state_q == FLUSH) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_d == 3'd0) begin
                state_d = RUN;
            end
        end

        if (accept) begin
            stk_push = 1'b1;
            take_d   = 1'b1;
            vpc_d    = vector_addr(VECTOR_BASE, VECTOR_SHIFT, int_addr);
            ie_d     = 1'b0;
            state_d  = FLUSH;
            cnt_d    = FLUSH_LOAD;
        end else if (do_ret) begin
            stk_pop  = 1'b1;
            rest_d   = 1'b1;
            rpc_d    = stk_top.pc;
            ie_d     = stk_top.ie;
            state_d  = FLUSH;
            cnt_d    = FLUSH_LOAD;
        end else if (set_ie) begin
            ie_d = 1'b1;
        end

        if (underflow) begin
            err_d = 1'b1;
        end
        if (clr_ie) begin
            ie_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            ie_q    <= 1'b0;
            take_q  <= 1'b0;
            rest_q  <= 1'b0;
            vpc_q   <= 16'h0000;
            rpc_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ie_q    <= ie_d;
            take_q  <= take_d;
            rest_q  <= rest_d;
            vpc_q   <= vpc_d;
            rpc_q   <= rpc_d;
            err_q   <= err_d;
        end
    end

    assign take_int      = take_q;
    assign vector_pc     = vpc_q;
    assign restore       = rest_q;
    assign restore_pc    = rpc_q;
    assign stall         = (state_q == FLUSH);
    assign ie            = ie_q;
    assign depth         = stk_depth;
    assign in_service    = (stk_depth != '0);
    assign cur_level     = (stk_depth != '0) ? stk_top.level : 3'd0;
    assign err_underflow = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed vector table, nesting/collision/reset
// sequences, and random traffic against a queue-based reference model.
module tb_interrupt_sequencer;
    import riptide_int_pkg::*;

    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst, int_rq, inst_boundary, reti, set_ie, clr_ie;
    logic [2:0]  int_addr;
    logic [15:0] pc_in;
    logic        take_int, restore, stall, ie, in_service, err_underflow;
    logic [15:0] vector_pc, restore_pc;
    logic [2:0]  depth, cur_level;
    seq_state_e  dbg_state;

    always #5 clk = ~clk;

    interrupt_sequencer #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst), .int_rq(int_rq), .int_addr(int_addr),
        .inst_boundary(inst_boundary), .pc_in(pc_in), .reti(reti),
        .set_ie(set_ie), .clr_ie(clr_ie), .take_int(take_int),
        .vector_pc(vector_pc), .restore(restore), .restore_pc(restore_pc),
        .stall(stall), .ie(ie), .depth(depth), .in_service(in_service),
        .cur_level(cur_level), .err_underflow(err_underflow), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic rst; logic rq; logic [2:0] addr; logic ib;
        logic [15:0] pc; logic reti; logic seti; logic clri;
    } in_t;

    typedef struct packed {
        logic take; logic [15:0] vpc; logic rest; logic [15:0] rpc;
        logic stall; logic ie; logic [2:0] depth; logic err;
    } out_t;

    typedef struct packed { in_t in; out_t exp; } vec_t;

    typedef struct { logic [15:0] pc; logic ie; logic [2:0] lvl; } m_ent_t;

    int errors = 0;
    int checks = 0;

    // Reference model: context kept in a queue, flush tracked as stall cycles left.
    m_ent_t      m_stk[$];
    logic        m_ie, m_err, m_take, m_rest;
    logic [15:0] m_vpc, m_rpc;
    int          m_flush;

    function automatic in_t mi(logic r, logic rq, logic [2:0] a, logic ib,
                               logic [15:0] pc, logic rt, logic s, logic c);
        in_t v;
        v = '{rst: r, rq: rq, addr: a, ib: ib, pc: pc, reti: rt, seti: s, clri: c};
        return v;
    endfunction

    function automatic out_t mo(logic t, logic [15:0] vpc, logic rs, logic [15:0] rpc,
                                logic st, logic e, logic [2:0] d, logic er);
        out_t o;
        o = '{take: t, vpc: vpc, rest: rs, rpc: rpc, stall: st, ie: e, depth: d, err: er};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input in_t v);
        logic   busy, accept, ret, new_ie;
        m_ent_t e;
        if (v.rst) begin
            m_stk.delete();
            m_ie = 0; m_err = 0; m_take = 0; m_rest = 0;
            m_vpc = 0; m_rpc = 0; m_flush = 0;
            return;
        end
        m_take = 0; m_rest = 0;
        busy = (m_flush > 0);
        accept = 0; ret = 0;
        if (!busy) begin
            if (v.reti) begin
                if (m_stk.size() > 0) ret = 1;
                else m_err = 1;
            end else if (v.rq && m_ie && v.ib && m_stk.size() < DEPTH) begin
                accept = 1;
            end
        end
        if (busy) m_flush--;
        new_ie = m_ie;
        if (accept) begin
            e.pc = v.pc; e.ie = m_ie; e.lvl = v.addr;
            m_stk.push_back(e);
            m_take = 1;
            m_vpc = 16'((32'h0010 + (32'(v.addr) * 4)) % 65536);
            new_ie = 0;
            m_flush = FLUSH_CYCLES;
        end else if (ret) begin
            e = m_stk.pop_back();
            m_rest = 1;
            m_rpc = e.pc;
            new_ie = e.ie;
            m_flush = FLUSH_CYCLES;
        end else if (v.seti) begin
            new_ie = 1;
        end
        if (v.clri) new_ie = 0;
        m_ie = new_ie;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = m_stk.size();
        check({tag, ".take_int"}, 32'(take_int), 32'(m_take));
        check({tag, ".vector_pc"}, 32'(vector_pc), 32'(m_vpc));
        check({tag, ".restore"}, 32'(restore), 32'(m_rest));
        check({tag, ".restore_pc"}, 32'(restore_pc), 32'(m_rpc));
        check({tag, ".stall"}, 32'(stall), 32'(m_flush > 0));
        check({tag, ".ie"}, 32'(ie), 32'(m_ie));
        check({tag, ".depth"}, 32'(depth), 32'(sz));
        check({tag, ".in_service"}, 32'(in_service), 32'(sz != 0));
        check({tag, ".cur_level"}, 32'(cur_level), (sz != 0) ? 32'(m_stk[sz-1].lvl) : 32'd0);
        check({tag, ".err"}, 32'(err_underflow), 32'(m_err));
    endtask

    task automatic tick(input in_t v, input string tag);
        rst = v.rst; int_rq = v.rq; int_addr = v.addr; inst_boundary = v.ib;
        pc_in = v.pc; reti = v.reti; set_ie = v.seti; clr_ie = v.clri;
        @(posedge clk);
        #1;
        model_step(v);
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        tick(mi(0, 0, 0, 0, 0, 0, 0, 0), tag);
    endtask

    vec_t vecs[14];

    initial begin
        rst = 1; int_rq = 0; int_addr = 0; inst_boundary = 0;
        pc_in = 0; reti = 0; set_ie = 0; clr_ie = 0;
        model_step(mi(1, 0, 0, 0, 0, 0, 0, 0));

        // Entry/return/underflow walkthrough with hand-derived expectations.
        vecs[0]  = '{in: mi(1, 0, 0, 0, 16'h0000, 0, 0, 0), exp: mo(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0)};
        vecs[1]  = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 1, 0), exp: mo(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0)};
        vecs[2]  = '{in: mi(0, 1, 3, 1, 16'h0123, 0, 0, 0), exp: mo(1, 16'h001C, 0, 16'h0000, 1, 0, 1, 0)};
        vecs[3]  = '{in: mi(0, 1, 3, 1, 16'h0123, 0, 0, 0), exp: mo(0, 16'h001C, 0, 16'h0000, 1, 0, 1, 0)};
        vecs[4]  = '{in: mi(0, 1, 3, 1, 16'h0123, 0, 0, 0), exp: mo(0, 16'h001C, 0, 16'h0000, 0, 0, 1, 0)};
        vecs[5]  = '{in: mi(0, 0, 0, 1, 16'h0000, 1, 0, 0), exp: mo(0, 16'h001C, 1, 16'h0123, 1, 1, 0, 0)};
        vecs[6]  = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 0, 0), exp: mo(0, 16'h001C, 0, 16'h0123, 1, 1, 0, 0)};
        vecs[7]  = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 0, 0), exp: mo(0, 16'h001C, 0, 16'h0123, 0, 1, 0, 0)};
        vecs[8]  = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 0, 1), exp: mo(0, 16'h001C, 0, 16'h0123, 0, 0, 0, 0)};
        vecs[9]  = '{in: mi(0, 0, 0, 1, 16'h0000, 1, 0, 0), exp: mo(0, 16'h001C, 0, 16'h0123, 0, 0, 0, 1)};
        vecs[10] = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 0, 0), exp: mo(0, 16'h001C, 0, 16'h0123, 0, 0, 0, 1)};
        vecs[11] = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 1, 1), exp: mo(0, 16'h001C, 0, 16'h0123, 0, 0, 0, 1)};
        vecs[12] = '{in: mi(0, 0, 0, 0, 16'h0000, 0, 1, 0), exp: mo(0, 16'h001C, 0, 16'h0123, 0, 1, 0, 1)};
        vecs[13] = '{in: mi(1, 0, 0, 0, 16'h0000, 0, 0, 0), exp: mo(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0)};

        for (int i = 0; i < 14; i++) begin
            out_t act;
            tick(vecs[i].in, $sformatf("vec%0d", i));
            act = mo(take_int, vector_pc, restore, restore_pc, stall, ie, depth, err_underflow);
            check($sformatf("tbl%0d.take", i), 32'(act.take), 32'(vecs[i].exp.take));
            check($sformatf("tbl%0d.vpc", i), 32'(act.vpc), 32'(vecs[i].exp.vpc));
            check($sformatf("tbl%0d.rest", i), 32'(act.rest), 32'(vecs[i].exp.rest));
            check($sformatf("tbl%0d.rpc", i), 32'(act.rpc), 32'(vecs[i].exp.rpc));
            check($sformatf("tbl%0d.stall", i), 32'(act.stall), 32'(vecs[i].exp.stall));
            check($sformatf("tbl%0d.ie", i), 32'(act.ie), 32'(vecs[i].exp.ie));
            check($sformatf("tbl%0d.depth", i), 32'(act.depth), 32'(vecs[i].exp.depth));
            check($sformatf("tbl%0d.err", i), 32'(act.err), 32'(vecs[i].exp.err));
        end

        // Five nested requests, handler re-enables ie each time; only four fit.
        tick(mi(0, 0, 0, 0, 0, 0, 1, 0), "nest.seti");
        for (int i = 0; i < 5; i++) begin
            logic [15:0] pc;
            pc = 16'((i + 1) * 16'h0100);
            tick(mi(0, 1, 3'(i), 1, pc, 0, 0, 0), "nest.req");
            check($sformatf("nest%0d.take", i), 32'(take_int), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("nest%0d.depth", i), 32'(depth), (i < 4) ? 32'(i + 1) : 32'd4);
            tick(mi(0, 1, 3'(i), 1, pc, 0, 1, 0), "nest.fl1");
            tick(mi(0, 1, 3'(i), 1, pc, 0, 0, 0), "nest.fl2");
        end
        check("nest.err_after_full", 32'(err_underflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(mi(0, 0, 0, 1, 0, 1, 0, 0), "unnest.reti");
            check($sformatf("unnest%0d.restore", i), 32'(restore), 32'd1);
            check($sformatf("unnest%0d.pc", i), 32'(restore_pc), 32'((4 - i) * 16'h0100));
            idle("unnest.fl1");
            idle("unnest.fl2");
        end
        check("unnest.ie", 32'(ie), 32'd1);
        check("unnest.depth", 32'(depth), 32'd0);

        // reti and a qualifying request together: restore first, entry after flush.
        tick(mi(1, 0, 0, 0, 0, 0, 0, 0), "col.rst");
        tick(mi(0, 0, 0, 0, 0, 0, 1, 0), "col.seti");
        tick(mi(0, 1, 1, 1, 16'h0200, 0, 0, 0), "col.enter");
        tick(mi(0, 1, 1, 1, 16'h0200, 0, 1, 0), "col.fl1");
        tick(mi(0, 1, 1, 1, 16'h0200, 0, 0, 0), "col.fl2");
        tick(mi(0, 1, 2, 1, 16'h0300, 1, 0, 0), "col.both");
        check("col.restore", 32'(restore), 32'd1);
        check("col.no_take", 32'(take_int), 32'd0);
        check("col.rpc", 32'(restore_pc), 32'h0200);
        tick(mi(0, 1, 2, 1, 16'h0300, 0, 0, 0), "col.fl1b");
        check("col.flush_no_take", 32'(take_int), 32'd0);
        tick(mi(0, 1, 2, 1, 16'h0300, 0, 0, 0), "col.fl2b");
        tick(mi(0, 1, 2, 1, 16'h0300, 0, 0, 0), "col.retake");
        check("col.take_after", 32'(take_int), 32'd1);
        check("col.vpc_after", 32'(vector_pc), 32'h0018);

        // Reset during a flush at depth 2 drops all context.
        tick(mi(1, 0, 0, 0, 0, 0, 0, 0), "rf.rst");
        tick(mi(0, 0, 0, 0, 0, 0, 1, 0), "rf.seti");
        tick(mi(0, 1, 5, 1, 16'h0AAA, 0, 0, 0), "rf.e1");
        tick(mi(0, 1, 5, 1, 16'h0AAA, 0, 1, 0), "rf.fl1");
        tick(mi(0, 1, 5, 1, 16'h0AAA, 0, 0, 0), "rf.fl2");
        tick(mi(0, 1, 6, 1, 16'h0BBB, 0, 0, 0), "rf.e2");
        check("rf.depth2", 32'(depth), 32'd2);
        check("rf.level", 32'(cur_level), 32'd6);
        tick(mi(1, 1, 6, 1, 16'h0BBB, 0, 0, 0), "rf.rst_mid");
        check("rf.depth0", 32'(depth), 32'd0);
        check("rf.stall0", 32'(stall), 32'd0);
        check("rf.ie0", 32'(ie), 32'd0);
        check("rf.no_restore", 32'(restore), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            in_t v;
            v.rst  = ($urandom_range(0, 199) == 0);
            v.rq   = ($urandom_range(0, 9) < 6);
            v.addr = 3'($urandom_range(0, 7));
            v.ib   = ($urandom_range(0, 9) < 7);
            v.pc   = 16'($urandom_range(0, 65535));
            v.reti = ($urandom_range(0, 99) < 15);
            v.seti = ($urandom_range(0, 99) < 30);
            v.clri = ($urandom_range(0, 99) < 5);
            tick(v, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
